// File: rtl/rom_loader.sv
// rom_loader: byte-stream ROM loader (count, words); ROM_LOADER_CHECKSUM_EN adds a trailing checksum check
module rom_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          MAX_WORDS = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [15:0] rom_in,
  output logic        rom_load,
  output logic [15:0] rom_address,
  output logic        busy,
  output logic        done,
  output logic        error
);
  typedef enum logic [3:0] {
    IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, DONE
`ifdef ROM_LOADER_CHECKSUM_EN
    , CHK_HI, CHK_LO
`endif
  } state_t;
  state_t state, nxt;
  logic [15:0] count, word, addr, len;
  logic err, acc, over;
`ifdef ROM_LOADER_CHECKSUM_EN
  localparam state_t tail = CHK_HI;
  logic [15:0] sum;
  assign byte_ready = state inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK_HI, CHK_LO};
`else
  localparam state_t tail = DONE;
  assign byte_ready = state inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO};
`endif
  assign acc = byte_valid & byte_ready;
  assign len = {count[15:8], byte_in};
  assign over = 32'(len) > MAX_WORDS;
  assign rom_in = word;
  assign rom_address = addr;
  assign rom_load = state == WRITE;
  assign busy = !(state inside {IDLE, DONE});
  assign done = state == DONE;
  assign error = err;
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE: nxt = start ? LEN_HI : state;
      LEN_HI:     nxt = acc ? LEN_LO : state;
      LEN_LO:     nxt = !acc ? state : over ? DONE : len == 16'd0 ? tail : DATA_HI;
      DATA_HI:    nxt = acc ? DATA_LO : state;
      DATA_LO:    nxt = acc ? WRITE : state;
      WRITE:      nxt = count == 16'd1 ? tail : DATA_HI;
`ifdef ROM_LOADER_CHECKSUM_EN
      CHK_HI:     nxt = acc ? CHK_LO : state;
      CHK_LO:     nxt = acc ? DONE : state;
`endif
      default:    nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      word  <= '0;
      addr  <= BASE_ADDR;
      err   <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
      sum   <= '0;
`endif
    end else begin
      state <= nxt;
      if (state inside {IDLE, DONE} && start) begin
        addr <= BASE_ADDR;
        err  <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
        sum  <= '0;
`endif
      end
      if (acc && state == LEN_HI) count[15:8] <= byte_in;
      if (acc && state == LEN_LO) begin
        count <= len;
        err   <= over;
      end
      if (acc && state == DATA_HI) word[15:8] <= byte_in;
      if (acc && state == DATA_LO) word[7:0] <= byte_in;
      if (state == WRITE) begin
        addr  <= addr + 16'd1;
        count <= count - 16'd1;
`ifdef ROM_LOADER_CHECKSUM_EN
        sum   <= sum + word;
`endif
      end
`ifdef ROM_LOADER_CHECKSUM_EN
      if (acc && state == CHK_HI) count[15:8] <= byte_in;
      if (acc && state == CHK_LO) err <= len != sum;
`endif
    end
  end
endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: randomized stream sessions checked against a word-list reference model
module tb_rom_loader;
  localparam logic [15:0] BASE0 = 16'h0000;
  localparam logic [15:0] BASE1 = 16'hFFFF;
  localparam int MAX1 = 8;
  logic clk = 0, reset = 1, start = 0, byte_valid = 0;
  logic [7:0] byte_in = 0;
  logic byte_ready0, rom_load0, busy0, done0, error0;
  logic byte_ready1, rom_load1, busy1, done1, error1;
  logic [15:0] rom_in0, rom_address0, rom_in1, rom_address1;
  int n_checks = 0, n_fail = 0;
  logic [31:0] exp0[$], exp1[$];
  logic [15:0] w[16];

  always #5 clk = ~clk;

  rom_loader dut0 (
    .clk(clk), .reset(reset), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready0), .rom_in(rom_in0), .rom_load(rom_load0), .rom_address(rom_address0),
    .busy(busy0), .done(done0), .error(error0)
  );
  rom_loader #(.BASE_ADDR(BASE1), .MAX_WORDS(MAX1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready1), .rom_in(rom_in1), .rom_load(rom_load1), .rom_address(rom_address1),
    .busy(busy1), .done(done1), .error(error1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] e;
    if (rom_load0) begin
      if (exp0.size() != 0) e = exp0.pop_front(); else e = 'x;
      check("write0", {rom_address0, rom_in0}, e);
    end
    if (rom_load1) begin
      if (exp1.size() != 0) e = exp1.pop_front(); else e = 'x;
      check("write1", {rom_address1, rom_in1}, e);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    logic ok = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      byte_valid = ($urandom_range(0, 2) != 0);
      byte_in = byte_valid ? b : 8'($urandom);
      start = (busy0 && busy1) ? ($urandom_range(0, 7) == 0) : 1'b0;
      ok = byte_valid && byte_ready0;
    end
    if (!ok) check("byte_accept", {31'd0, ok}, 1);
  endtask

  task automatic start_session();
    @(negedge clk);
    byte_valid = 0;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic run_session(input int n, input logic [15:0] mask);
    logic [15:0] sum = 0;
    logic [15:0] nn = 16'(n);
    logic chk_err = 0;
    int k = 0;
    for (int i = 0; i < n; i++) begin
      sum += w[i];
      exp0.push_back({BASE0 + 16'(i), w[i]});
      if (n <= MAX1) exp1.push_back({BASE1 + 16'(i), w[i]});
    end
    start_session();
    send_byte(nn[15:8]);
    send_byte(nn[7:0]);
    for (int i = 0; i < n; i++) begin
      send_byte(w[i][15:8]);
      send_byte(w[i][7:0]);
    end
`ifdef ROM_LOADER_CHECKSUM_EN
    sum ^= mask;
    chk_err = mask != 0;
    send_byte(sum[15:8]);
    send_byte(sum[7:0]);
`endif
    do begin
      @(negedge clk);
      byte_valid = 0;
      start = 0;
      k++;
    end while (!(done0 && done1) && k < 30);
    check("done0", done0, 1);
    check("done1", done1, 1);
    check("busy0", busy0, 0);
    check("error0", error0, chk_err);
    check("error1", error1, (n > MAX1) ? 1 : chk_err);
    check("pending0", exp0.size(), 0);
    check("pending1", exp1.size(), 0);
`ifndef ROM_LOADER_CHECKSUM_EN
    if (n == 0) check("n0_latency", k, 1);
`endif
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready", byte_ready0, 0);
    check("rst_load", rom_load0, 0);
    check("rst_rom_in", rom_in0, 0);
    check("rst_addr0", rom_address0, BASE0);
    check("rst_addr1", rom_address1, BASE1);
    check("rst_status", {busy0, done0, error0}, 0);
    reset = 0;
    w[0] = 16'h1234; w[1] = 16'hABCD;
    run_session(2, 0);
    w[0] = 16'h0001; w[1] = 16'h0002;
    run_session(2, 0);
    run_session(0, 0);
`ifdef ROM_LOADER_CHECKSUM_EN
    w[0] = 16'h1234; w[1] = 16'hABCD;
    run_session(2, 16'h0003);
`endif
    start_session();
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h12);
    @(negedge clk);
    reset = 1; start = 1; byte_valid = 1; byte_in = 8'hAB;
    @(negedge clk);
    reset = 0; start = 0; byte_valid = 0;
    check("mid_rst_ready", byte_ready0, 0);
    check("mid_rst_load", rom_load0, 0);
    check("mid_rst_rom_in", rom_in0, 0);
    check("mid_rst_addr1", rom_address1, BASE1);
    check("mid_rst_status", {busy0, done0, error0, busy1, done1, error1}, 0);
    w[0] = 16'h1234; w[1] = 16'hABCD;
    run_session(2, 0);
    for (int i = 0; i < 9; i++) w[i] = 16'($urandom);
    run_session(MAX1, 0);
    run_session(MAX1 + 1, 0);
    for (int s = 0; s < 12; s++) begin
      int n = $urandom_range(0, 12);
      for (int i = 0; i < n; i++) w[i] = 16'($urandom);
      run_session(n, ($urandom_range(0, 1) != 0) ? 16'($urandom_range(1, 65535)) : 16'h0000);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
